// File: rtl/bpu_gshare.sv
// Branch prediction unit: direct-mapped tagged BTB plus a PHT of saturating
// counters, indexed bimodally or by gshare (PC XOR speculative global history).
// Predicts combinationally at Fetch, trains from Execute, repairs history on
// a resolved misprediction and counts resolved/mispredicted conditionals.
module bpu_gshare #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned PRED_MODE   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           stall_i,
  input  logic [XLEN-1:0]                pc_i,
  output logic                           branch_hit_o,
  output logic                           branch_decision_o,
  output logic [XLEN-1:0]                branch_target_addr_o,
  output logic [$clog2(PHT_ENTRIES)-1:0] pred_pht_idx_o,
  output logic [GHR_BITS-1:0]            pred_ghr_o,
  input  logic                           exe_valid_i,
  input  logic                           exe_is_cond_i,
  input  logic [XLEN-1:0]                exe_pc_i,
  input  logic [$clog2(PHT_ENTRIES)-1:0] exe_pht_idx_i,
  input  logic [GHR_BITS-1:0]            exe_ghr_i,
  input  logic                           branch_taken_i,
  input  logic                           branch_misprediction_i,
  input  logic [XLEN-1:0]                branch_target_addr_i,
  output logic [31:0]                    cond_cnt_o,
  output logic [31:0]                    mispred_cnt_o
);

  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);
  localparam int unsigned TAG_W  = XLEN - BTB_IW - 2;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);

  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
  logic                btb_cond   [BTB_ENTRIES];
  logic [CNT_BITS-1:0] pht        [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  logic [BTB_IW-1:0]   f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic [BTB_IW-1:0]   e_idx;
  logic [TAG_W-1:0]    e_tag;
  logic [PHT_IW-1:0]   ghr_ext;
  logic                hit;
  logic                f_cond;
  logic                decision;
  logic [CNT_BITS-1:0] pht_cur;
  logic [CNT_BITS-1:0] pht_next;
  logic                unused_pc_bits;

  // Shift one outcome into a history value; the widened concat keeps
  // GHR_BITS=1 legal without a special case.
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                   input logic b);
    logic [GHR_BITS:0] t;
    t = {h, b};
    return t[GHR_BITS-1:0];
  endfunction

  assign f_idx = pc_i[BTB_IW+1:2];
  assign f_tag = pc_i[XLEN-1:BTB_IW+2];
  assign e_idx = exe_pc_i[BTB_IW+1:2];
  assign e_tag = exe_pc_i[XLEN-1:BTB_IW+2];
  assign unused_pc_bits = ^exe_pc_i[1:0];

  // Zero-extend the history to PHT index width
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = ghr;
  end

  assign pred_pht_idx_o = (PRED_MODE == 0) ? pc_i[PHT_IW+1:2]
                                           : (pc_i[PHT_IW+1:2] ^ ghr_ext);
  assign pred_ghr_o     = ghr;

  // Fetch-side lookup and direction decision
  always_comb begin
    hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag) && (pc_i != '0);
    f_cond   = btb_cond[f_idx];
    decision = 1'b0;
    if (hit) decision = f_cond ? pht[pred_pht_idx_o][CNT_BITS-1] : 1'b1;
  end

  assign branch_hit_o         = hit;
  assign branch_decision_o    = decision;
  assign branch_target_addr_o = hit ? btb_target[f_idx] : '0;

  // Saturating counter step for the Execute-side training write
  always_comb begin
    pht_cur  = pht[exe_pht_idx_i];
    pht_next = pht_cur;
    if (branch_taken_i && (pht_cur != '1))       pht_next = pht_cur + 1'b1;
    else if (!branch_taken_i && (pht_cur != '0)) pht_next = pht_cur - 1'b1;
  end

  // Speculative history: misprediction repair takes priority over Fetch shift
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ghr <= '0;
    end else if (!stall_i) begin
      if (exe_valid_i && branch_misprediction_i)
        ghr <= exe_is_cond_i ? shift_in(exe_ghr_i, branch_taken_i) : exe_ghr_i;
      else if (hit && f_cond)
        ghr <= shift_in(ghr, decision);
    end
  end

  // PHT training and performance counters from resolved conditionals
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) pht[i] <= CNT_INIT;
      cond_cnt_o    <= '0;
      mispred_cnt_o <= '0;
    end else if (!stall_i && exe_valid_i && exe_is_cond_i) begin
      pht[exe_pht_idx_i] <= pht_next;
      cond_cnt_o         <= cond_cnt_o + 32'd1;
      mispred_cnt_o      <= mispred_cnt_o + {31'd0, branch_misprediction_i};
    end
  end

  // BTB valid bits: only taken branches allocate
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (!stall_i && exe_valid_i && branch_taken_i) begin
      btb_valid[e_idx] <= 1'b1;
    end
  end

  // BTB payload; qualified by valid so it needs no reset
  always_ff @(posedge clk_i) begin
    if (rst_ni && !stall_i && exe_valid_i && branch_taken_i) begin
      btb_tag[e_idx]    <= e_tag;
      btb_target[e_idx] <= branch_target_addr_i;
      btb_cond[e_idx]   <= exe_is_cond_i;
    end
  end

endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare (default parameters, gshare mode):
// directed scenarios followed by randomized traffic against a reference model.
module tb_bpu_gshare;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        branch_hit_o;
  logic        branch_decision_o;
  logic [31:0] branch_target_addr_o;
  logic [7:0]  pred_pht_idx_o;
  logic [7:0]  pred_ghr_o;
  logic        exe_valid_i = 1'b0;
  logic        exe_is_cond_i = 1'b0;
  logic [31:0] exe_pc_i = '0;
  logic [7:0]  exe_pht_idx_i = '0;
  logic [7:0]  exe_ghr_i = '0;
  logic        branch_taken_i = 1'b0;
  logic        branch_misprediction_i = 1'b0;
  logic [31:0] branch_target_addr_i = '0;
  logic [31:0] cond_cnt_o;
  logic [31:0] mispred_cnt_o;

  always #5 clk_i = ~clk_i;

  bpu_gshare #(
    .XLEN(32), .BTB_ENTRIES(64), .PHT_ENTRIES(256),
    .CNT_BITS(2), .GHR_BITS(8), .PRED_MODE(1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .pc_i(pc_i),
    .branch_hit_o(branch_hit_o), .branch_decision_o(branch_decision_o),
    .branch_target_addr_o(branch_target_addr_o),
    .pred_pht_idx_o(pred_pht_idx_o), .pred_ghr_o(pred_ghr_o),
    .exe_valid_i(exe_valid_i), .exe_is_cond_i(exe_is_cond_i),
    .exe_pc_i(exe_pc_i), .exe_pht_idx_i(exe_pht_idx_i), .exe_ghr_i(exe_ghr_i),
    .branch_taken_i(branch_taken_i),
    .branch_misprediction_i(branch_misprediction_i),
    .branch_target_addr_i(branch_target_addr_i),
    .cond_cnt_o(cond_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: each BTB slot remembers the full PC that owns it
  bit          m_valid [64];
  logic [31:0] m_owner [64];
  logic [31:0] m_tgt   [64];
  bit          m_cond  [64];
  int          m_pht   [256];
  int unsigned m_ghr;
  logic [31:0] m_cond_cnt, m_mis_cnt;
  bit          m_known = 1'b0;

  function automatic void predict(input logic [31:0] pc, output bit hit, output bit dec,
                                  output logic [31:0] tgt, output int unsigned pidx);
    int unsigned e;
    e    = (pc >> 2) % 64;
    hit  = m_valid[e] && ((m_owner[e] >> 8) == (pc >> 8)) && (pc != 0);
    pidx = ((pc >> 2) ^ m_ghr) % 256;
    dec  = hit && (m_cond[e] ? (m_pht[pidx] >= 2) : 1'b1);
    tgt  = hit ? m_tgt[e] : 32'd0;
  endfunction

  // Drive one cycle: set inputs after negedge, compare, advance the model
  task automatic cycle(input bit rst, input bit stall, input logic [31:0] pc,
                       input bit ev, input bit ec, input logic [31:0] epc,
                       input logic [7:0] eidx, input logic [7:0] eghr,
                       input bit tk, input bit mis, input logic [31:0] etgt);
    bit hit, dec;
    logic [31:0] tgt;
    int unsigned pidx, fe, we, ng;
    @(negedge clk_i);
    rst_ni = rst; stall_i = stall; pc_i = pc;
    exe_valid_i = ev; exe_is_cond_i = ec; exe_pc_i = epc;
    exe_pht_idx_i = eidx; exe_ghr_i = eghr;
    branch_taken_i = tk; branch_misprediction_i = mis; branch_target_addr_i = etgt;
    #1;
    predict(pc, hit, dec, tgt, pidx);
    if (m_known) begin
      check("hit", {31'd0, branch_hit_o}, {31'd0, hit});
      check("decision", {31'd0, branch_decision_o}, {31'd0, dec});
      check("target", branch_target_addr_o, tgt);
      check("pht_idx", {24'd0, pred_pht_idx_o}, pidx);
      check("ghr", {24'd0, pred_ghr_o}, m_ghr);
      check("cond_cnt", cond_cnt_o, m_cond_cnt);
      check("mispred_cnt", mispred_cnt_o, m_mis_cnt);
    end
    if (!rst) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      m_ghr = 0; m_cond_cnt = '0; m_mis_cnt = '0; m_known = 1'b1;
    end else if (!stall) begin
      fe = (pc >> 2) % 64;
      ng = m_ghr;
      if (ev && mis) ng = ec ? (((eghr << 1) | tk) & 255) : eghr;
      else if (hit && m_cond[fe]) ng = ((m_ghr << 1) | dec) & 255;
      if (ev && ec) begin
        if (tk) m_pht[eidx] = (m_pht[eidx] < 3) ? m_pht[eidx] + 1 : 3;
        else    m_pht[eidx] = (m_pht[eidx] > 0) ? m_pht[eidx] - 1 : 0;
        m_cond_cnt = m_cond_cnt + 1;
        if (mis) m_mis_cnt = m_mis_cnt + 1;
      end
      if (ev && tk) begin
        we = (epc >> 2) % 64;
        m_valid[we] = 1'b1; m_owner[we] = epc; m_tgt[we] = etgt; m_cond[we] = ec;
      end
      m_ghr = ng;
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(1, 0, pc, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
  endtask

  logic [31:0] pool [8];
  logic [31:0] cc_before, mc_before;

  initial begin
    pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1100; pool[2] = 32'h0000_1104;
    pool[3] = 32'h0000_2008; pool[4] = 32'h0001_1000; pool[5] = 32'h0000_0000;
    pool[6] = 32'h0000_30FC; pool[7] = 32'h0000_1040;

    // Reset held two cycles, then first look-up misses
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(32'h1000);
    check("rst_hit", {31'd0, branch_hit_o}, 32'd0);
    check("rst_dec", {31'd0, branch_decision_o}, 32'd0);
    check("rst_tgt", branch_target_addr_o, 32'd0);
    check("rst_cnt", cond_cnt_o | mispred_cnt_o, 32'd0);

    // JAL allocates; next fetch hits taken, history untouched
    cycle(1, 0, 0, 1, 0, 32'h1000, 0, 0, 1, 0, 32'h2000);
    idle(32'h1000);
    check("jal_hit", {31'd0, branch_hit_o}, 32'd1);
    check("jal_dec", {31'd0, branch_decision_o}, 32'd1);
    check("jal_tgt", branch_target_addr_o, 32'h2000);
    idle(0);
    check("jal_ghr", {24'd0, pred_ghr_o}, 32'd0);

    // Conditional at 0x1104 trained taken; index 0x41 with GHR=0
    cycle(1, 0, 0, 1, 1, 32'h1104, 8'h41, 0, 1, 0, 32'h1200);
    cycle(1, 0, 32'h1104, 1, 1, 32'h1104, 8'h41, 0, 1, 0, 32'h1200);
    check("cond_dec", {31'd0, branch_decision_o}, 32'd1);
    cycle(1, 0, 0, 1, 1, 32'h1104, 8'h41, 0, 1, 0, 32'h1200);
    idle(0);
    check("cond_cnt3", cond_cnt_o, 32'd3);
    check("cond_ghr1", {24'd0, pred_ghr_o}, 32'd1);

    // GHR=5 via JAL repair, then a taken conditional hit shifts to 0x0B
    cycle(1, 0, 0, 1, 1, 32'h1104, 8'h44, 0, 1, 0, 32'h1200);
    cycle(1, 0, 0, 1, 0, 32'h3008, 0, 8'h05, 1, 1, 32'h3100);
    idle(32'h1104);
    check("g5_ghr", {24'd0, pred_ghr_o}, 32'h05);
    check("g5_dec", {31'd0, branch_decision_o}, 32'd1);
    cycle(1, 0, 32'h1104, 1, 1, 32'h1104, 8'h10, 8'h05, 0, 1, 0);
    check("g0b_ghr", {24'd0, pred_ghr_o}, 32'h0B);
    idle(0);
    check("repair_ghr", {24'd0, pred_ghr_o}, 32'h0A);

    // Stall freezes every piece of state
    cc_before = cond_cnt_o; mc_before = mispred_cnt_o;
    cycle(1, 1, 32'h1104, 1, 1, 32'h2204, 8'h4B, 0, 1, 1, 32'h7000);
    idle(32'h2204);
    check("stall_btb", {31'd0, branch_hit_o}, 32'd0);
    check("stall_ghr", {24'd0, pred_ghr_o}, 32'h0A);
    check("stall_cc", cond_cnt_o, cc_before);
    check("stall_mc", mispred_cnt_o, mc_before);
    idle(32'h1104);
    check("stall_pht", {31'd0, branch_decision_o}, 32'd0);

    // Aliasing: 0x1100 evicts the 0x1000 entry
    cycle(1, 0, 0, 1, 1, 32'h1100, 8'h00, 0, 1, 0, 32'h5000);
    idle(32'h1000);
    check("alias_miss", {31'd0, branch_hit_o}, 32'd0);
    idle(32'h1100);
    check("alias_tgt", branch_target_addr_o, 32'h5000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc, repc;
      rpc  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
      repc = pool[$urandom_range(0, 7)];
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0), rpc,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), repc,
            8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bpu_gshare.md
Name: bpu_gshare

Overview:
Parameterised successor branch prediction unit for the in-order RISC-V core.
- Holds a direct-mapped, tagged branch target buffer (BTB) and a pattern history table (PHT) of N-bit saturating counters.
- The PHT is indexed bimodally or by gshare (PC XOR speculative global history).
- Predicts combinationally at Fetch and updates from Execute, using a PHT index and history snapshot that travel down the pipeline with the instruction.
- Repairs the speculative history on misprediction and keeps performance counters.

Parameters:
XLEN, 32, address width
BTB_ENTRIES, 64, BTB entries (power of 2, >=2)
PHT_ENTRIES, 256, PHT counters (power of 2, >=2)
CNT_BITS, 2, saturating counter width (1..4)
GHR_BITS, 8, global history length (1..log2(PHT_ENTRIES))
PRED_MODE, 1, 0 = bimodal, 1 = gshare

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
stall_i  in  1  pipeline stall; freezes all state
pc_i  in  XLEN  Fetch PC
branch_hit_o  out  1  BTB hit for pc_i
branch_decision_o  out  1  predicted taken
branch_target_addr_o  out  XLEN  predicted target
pred_pht_idx_o  out  log2(PHT_ENTRIES)  PHT index used for pc_i (pipelined to Execute)
pred_ghr_o  out  GHR_BITS  GHR value before this prediction (pipelined)
exe_valid_i  in  1  Execute holds a conditional branch or JAL
exe_is_cond_i  in  1  that instruction is a conditional branch
exe_pc_i  in  XLEN  its PC
exe_pht_idx_i  in  log2(PHT_ENTRIES)  its pipelined PHT index
exe_ghr_i  in  GHR_BITS  its pipelined GHR snapshot
branch_taken_i  in  1  resolved direction (1 for JAL)
branch_misprediction_i  in  1  resolved mispredict
branch_target_addr_i  in  XLEN  resolved target
cond_cnt_o  out  32  resolved conditional branches
mispred_cnt_o  out  32  mispredicted conditional branches

Behaviour:
Reset (rst_ni=0 at posedge):
- All BTB valid bits clear.
- PHT counters set to weakly-not-taken, 2^(CNT_BITS-1)-1.
- GHR = 0; both performance counters = 0.
- Outputs follow: branch_hit_o=0, branch_decision_o=0, branch_target_addr_o=0.
- Reset wins over every other event.

Stall: stall_i=1 blocks every state write (BTB, PHT, GHR, counters). Outputs stay combinational.

BTB:
- Index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits.
- Each entry holds: valid, tag, target, is_cond.

Fetch prediction (combinational, same cycle):
- hit = valid & tag match & (pc_i != 0).
- pred_pht_idx_o:
  - gshare: pc_i[log2(PHT_ENTRIES)+1:2] XOR zero-extended GHR.
  - bimodal: pc_i bits only.
- pred_ghr_o = current GHR.
- Miss: decision=0, target=0.
- Hit and JAL entry: decision=1.
- Hit and conditional entry: decision = MSB of PHT[pred_pht_idx_o].
- On hit, target = stored target.

Speculative GHR:
- If ~stall_i, hit and the entry is conditional: GHR <= {GHR[GHR_BITS-2:0], decision}.
- Misprediction repair (exe_valid_i & branch_misprediction_i & ~stall_i) overrides any Fetch update in the same cycle:
  - conditional: GHR <= {exe_ghr_i[GHR_BITS-2:0], branch_taken_i}.
  - JAL: GHR <= exe_ghr_i.

Execute update (~stall_i & exe_valid_i), one-cycle write latency:
- Conditional branch:
  - PHT[exe_pht_idx_i] increments if taken, decrements otherwise.
  - Saturates at 0 and at 2^CNT_BITS-1.
  - cond_cnt_o += 1; mispred_cnt_o += branch_misprediction_i.
- BTB allocate or overwrite only when branch_taken_i=1 at the entry indexed by exe_pc_i: valid=1, tag, target=branch_target_addr_i, is_cond=exe_is_cond_i.
- Not-taken branches never allocate.
- Same-cycle Fetch read of an entry being written returns the old contents; there is no bypass.
- Aliased entries are overwritten; there is no replacement policy beyond direct mapping.
- Performance counters wrap at 2^32.

Test Plan:
1. Hold rst_ni=0 for 2 cycles, then release; drive pc_i=0x1000 -> branch_hit_o=0, decision=0, target=0; cond_cnt_o=mispred_cnt_o=0.
2. JAL at exe_pc_i=0x1000, target 0x2000, taken, exe_is_cond_i=0; next cycle pc_i=0x1000 -> hit=1, decision=1, target=0x2000; GHR unchanged.
3. Conditional branch at 0x1100 resolved taken 3 times with CNT_BITS=2, PRED_MODE=0 -> counter goes 1→2→3→3; decision=1 after the first update; cond_cnt_o=3.
4. PRED_MODE=1, GHR=0x05, hit on a conditional entry predicting taken -> GHR=0x0B next cycle. Same cycle as exe mispredict with exe_ghr_i=0x05 and taken=0 -> GHR=0x0A (repair wins).
5. stall_i=1 during a taken Execute update and a Fetch hit -> BTB, PHT, GHR and counters unchanged after the cycle.
6. Two taken branches aliasing the same BTB index (PCs 0x1000 and 0x1100, BTB_ENTRIES=64) -> the second overwrites the first; pc_i=0x1000 then misses.
